ring_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters.
- Priority is held in a one-hot ring pointer that rotates like the team's ring counter: the MSB is hot at reset, it shifts toward the LSB, and bit 0 wraps to bit N-1.
- It grants one requester at a time, holds the grant until release or timeout, then advances priority past the last owner.
- It sits in front of any shared datapath element (bus, memory port, shared counter) driven by the sequential blocks.

---
 rtl/ring_arb_pkg.sv | 41 ++++
 rtl/rr_pick.sv | 54 +++++
 rtl/ring_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_ring_rr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ring_arb_pkg
// Purpose  : Shared definitions for the ring round-robin arbiter: FSM state
//            encoding and one-hot helper functions.
// Contents : IDLE / OWNED state constants, onehot_rotr(), onehot2bin().
// Revision : 1.0 - initial release
// ============================================================================
package ring_arb_pkg;

    // Helpers work on a fixed maximum width. Callers size-cast in and out,
    // which keeps the functions usable for any requester count up to MAX_N.
    localparam int MAX_N = 64;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    // Rotate the low n bits of vec right by one; bit 0 wraps into bit n-1.
    // Bits at and above n are expected to be zero on entry.
    function automatic logic [MAX_N-1:0] onehot_rotr(input logic [MAX_N-1:0] vec,
                                                     input int               n);
        logic [MAX_N-1:0] r;
        r        = vec >> 1;
        r[n-1]   = r[n-1] | vec[0];
        return r;
    endfunction

    // Binary index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic int onehot2bin(input logic [MAX_N-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set bit
//            of req found by searching downward from the ptr position
//            (ptr bit first), wrapping from bit 0 to bit N-1.
// Ports    : req        [N-1:0] in   request vector
//            ptr        [N-1:0] in   one-hot priority pointer
//            pick       [N-1:0] out  one-hot selection (zero if no request)
//            pick_valid         out  high when any request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] pick,
    output logic         pick_valid
);

    // Thermometer of bits 0..p where p is the ptr position. The upper copy of
    // req is masked with it, so in the double-width vector {req & mask, req}
    // the highest set bit is exactly the first hit of the downward, wrapping
    // search that starts at p.
    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;

    assign w_mask = ptr | (ptr - {{(N-1){1'b0}}, 1'b1});
    assign w_hi   = req & w_mask;

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        // Ascending scans, later hits overwrite: the last hit is the highest
        // index of the double-width vector (upper half dominates).
        for (int j = 0; j < N; j++) begin
            if (req[j]) begin
                pick       = '0;
                pick[j]    = 1'b1;
                pick_valid = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (w_hi[j]) begin
                pick       = '0;
                pick[j]    = 1'b1;
                pick_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ring_rr_arbiter
// Purpose  : Round-robin arbiter sharing one resource among N requesters.
//            A one-hot ring pointer (MSB hot at reset) sets priority; a
//            grant is held until release or MAX_HOLD timeout, after which
//            the pointer moves one position below the last owner.
// Ports    : clk                 in   clock, rising edge
//            reset               in   asynchronous active-high reset
//            req       [N-1:0]   in   request vector
//            grant     [N-1:0]   out  one-hot grant or zero (registered)
//            grant_idx [IW-1:0]  out  binary index of owner, 0 when idle
//            busy                out  high while grant is nonzero
//            timeout             out  one-cycle pulse on MAX_HOLD revocation
// Revision : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          busy,
    output logic          timeout
);

    // Hold counter wide enough to reach MAX_HOLD; one bit when timeout is off.
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    logic [0:0]    state_q,     state_d;
    logic [N-1:0]  ptr_q,       ptr_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
    logic [N-1:0]  grant_q,     grant_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic          timeout_q,   timeout_d;

    logic [N-1:0]  w_pick;
    logic          w_pick_valid;
    logic          w_release;
    logic          w_expire;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .pick       (w_pick),
        .pick_valid (w_pick_valid)
    );

    // Only the owner's own request bit matters while OWNED.
    assign w_release = (state_q == OWNED) && ((req & grant_q) == '0);
    assign w_expire  = (state_q == OWNED) && !w_release && (MAX_HOLD != 0) &&
                       (hold_cnt_q == HW'(MAX_HOLD));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= {1'b1, {(N-1){1'b0}}};
            hold_cnt_q  <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    state_d    = OWNED;
                    hold_cnt_d = HW'(1);
                end
            end
            OWNED: begin
                if (w_release || w_expire) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    // Previous owner drops to lowest priority next round.
                    ptr_d      = N'(onehot_rotr(MAX_N'(grant_q), N));
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic (registered through grant_q / grant_idx_q / timeout_q)
    always_comb begin
        grant_d   = grant_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = w_pick;
            end
            OWNED: begin
                if (w_release || w_expire) begin
                    grant_d = '0;
                end
                timeout_d = w_expire;
            end
            default: begin
                grant_d = '0;
            end
        endcase
        grant_idx_d = IW'(onehot2bin(MAX_N'(grant_d)));
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = |grant_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_rr_arbiter
// Purpose  : Directed self-checking bench for ring_rr_arbiter (N=4,
//            MAX_HOLD=4) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          timeout;

    int n_checks;
    int n_errors;

    ring_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant, index, busy, timeout and one-hot property in one go.
    task automatic check_out(input string tag, input logic [N-1:0] g,
                             input logic [IW-1:0] idx, input logic to);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".idx"},   32'(grant_idx), 32'(idx));
        check_eq({tag, ".busy"},  32'(busy), 32'(g != '0));
        check_eq({tag, ".tmo"},   32'(timeout), 32'(to));
        check_eq({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'(1));
    endtask

    initial begin
        logic [N-1:0] seq [5];
        seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b0010;
        seq[3] = 4'b0001; seq[4] = 4'b1000;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        req      = '0;
        step();
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        // Basic grant from ptr=1000: search 3,2 -> requester 2.
        req = 4'b0101;
        step();
        check_out("first", 4'b0100, 2'd2, 1'b0);

        // Release of 2, gap, then ptr=0010 searches 1,0 -> requester 0.
        req = 4'b0001;
        step();
        check_out("gap1", 4'b0000, 2'd0, 1'b0);
        step();
        check_out("second", 4'b0001, 2'd0, 1'b0);

        // Owner 0 releases: ptr wraps to 1000, so 3 beats 0.
        req = 4'b1000;
        step();
        check_out("gap2", 4'b0000, 2'd0, 1'b0);
        req = 4'b1001;
        step();
        check_out("wrap", 4'b1000, 2'd3, 1'b0);

        // Release, ptr=0100, then idle with no requests.
        req = 4'b0000;
        step();
        check_out("rel3", 4'b0000, 2'd0, 1'b0);
        step();
        check_out("idle", 4'b0000, 2'd0, 1'b0);

        // Timeout: single requester held for MAX_HOLD cycles.
        req = 4'b0010;
        for (int c = 0; c < MAX_HOLD; c++) begin
            step();
            check_out($sformatf("hold%0d", c), 4'b0010, 2'd1, 1'b0);
        end
        step();
        check_out("tmo", 4'b0000, 2'd0, 1'b1);
        step();
        check_out("regrant", 4'b0010, 2'd1, 1'b0);

        // Release; ptr becomes 0001.
        req = 4'b0000;
        step();
        check_out("rel1", 4'b0000, 2'd0, 1'b0);

        // From ptr=0001 search 0,3,2 -> requester 2, then async reset mid-cycle.
        req = 4'b0100;
        step();
        check_out("pre_rst", 4'b0100, 2'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b0000;
        step();
        reset = 1'b0;

        // Fairness after reset: ptr back at 1000.
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("fair%0d_a", i), seq[i], IW'(i % 4 == 0 ? 3 : 3 - i), 1'b0);
            step();
            check_out($sformatf("fair%0d_b", i), seq[i], IW'(i % 4 == 0 ? 3 : 3 - i), 1'b0);
            if (i < 4) begin
                req = 4'b1111 & ~seq[i];
                step();
                check_out($sformatf("fair%0d_gap", i), 4'b0000, 2'd0, 1'b0);
                req = 4'b1111;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
